// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the ALU drive/return path,
// and the response/flag outputs of alu_arbiter.
interface alu_arbiter_if;
    logic        req0_vld;
    logic        req0_rdy;
    logic [3:0]  req0_op;
    logic [15:0] req0_src0;
    logic [15:0] req0_src1;
    logic [3:0]  req0_shamt;
    logic        req1_vld;
    logic        req1_rdy;
    logic [3:0]  req1_op;
    logic [15:0] req1_src0;
    logic [15:0] req1_src1;
    logic [3:0]  req1_shamt;
    logic [3:0]  alu_op;
    logic [15:0] alu_src0;
    logic [15:0] alu_src1;
    logic [3:0]  alu_shamt;
    logic [15:0] alu_dst;
    logic        alu_ov;
    logic        alu_zr;
    logic        alu_neg;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic        rsp_id;
    logic [15:0] rsp_dst;
    logic        rsp_ov;
    logic        rsp_zr;
    logic        rsp_neg;
    logic [2:0]  flags0;
    logic [2:0]  flags1;

    modport slave (
        input  req0_vld, req0_op, req0_src0, req0_src1, req0_shamt,
        input  req1_vld, req1_op, req1_src0, req1_src1, req1_shamt,
        input  alu_dst, alu_ov, alu_zr, alu_neg, rsp_rdy,
        output req0_rdy, req1_rdy,
        output alu_op, alu_src0, alu_src1, alu_shamt,
        output rsp_vld, rsp_id, rsp_dst, rsp_ov, rsp_zr, rsp_neg,
        output flags0, flags1
    );

    modport master (
        output req0_vld, req0_op, req0_src0, req0_src1, req0_shamt,
        output req1_vld, req1_op, req1_src0, req1_src1, req1_shamt,
        output alu_dst, alu_ov, alu_zr, alu_neg, rsp_rdy,
        input  req0_rdy, req1_rdy,
        input  alu_op, alu_src0, alu_src1, alu_shamt,
        input  rsp_vld, rsp_id, rsp_dst, rsp_ov, rsp_zr, rsp_neg,
        input  flags0, flags1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared 16-bit ALU, with response
// handshake and per-requester {Z,N,V} flag registers.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        gnt0, gnt1, hs;
    logic [3:0]  op_q, shamt_q;
    logic [15:0] src0_q, src1_q, dst_q;
    logic        id_q, ov_q, zr_q, neg_q;
    logic [2:0]  flags0_q, flags0_d, flags1_q, flags1_d, upd;
    logic        arith, lgsh;

    // Tie goes to the port that did not win last (last_q=1 -> port 0).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            unique case (1'b1)
                bus.req0_vld && !bus.req1_vld: gnt0 = 1'b1;
                bus.req1_vld && !bus.req0_vld: gnt1 = 1'b1;
                bus.req0_vld && bus.req1_vld: begin
                    gnt0 = !RR_EN || last_q;
                    gnt1 = !gnt0;
                end
                default: ;
            endcase
        end
    end

    assign hs = (state_q == RESP) && bus.rsp_rdy;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d = EXEC;
                    last_d  = gnt1;
                end
            end
            EXEC: state_d = RESP;
            RESP: if (bus.rsp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // op_q still holds the owning op while the response is pending.
    assign arith = op_q <= 4'd2;
    assign lgsh  = op_q[3:2] == 2'b01;
    assign upd   = arith ? {zr_q, neg_q, ov_q} : {zr_q, 2'b00};

    always_comb begin
        flags0_d = flags0_q;
        flags1_d = flags1_q;
        if (hs && (arith || lgsh)) begin
            if (id_q) flags1_d = upd;
            else      flags0_d = upd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            flags0_q <= 3'b000;
            flags1_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            flags0_q <= flags0_d;
            flags1_q <= flags1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 4'd0;
            src0_q  <= 16'd0;
            src1_q  <= 16'd0;
            shamt_q <= 4'd0;
            id_q    <= 1'b0;
            dst_q   <= 16'd0;
            ov_q    <= 1'b0;
            zr_q    <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            if (gnt0 || gnt1) begin
                op_q    <= gnt1 ? bus.req1_op    : bus.req0_op;
                src0_q  <= gnt1 ? bus.req1_src0  : bus.req0_src0;
                src1_q  <= gnt1 ? bus.req1_src1  : bus.req0_src1;
                shamt_q <= gnt1 ? bus.req1_shamt : bus.req0_shamt;
                id_q    <= gnt1;
            end
            if (state_q == EXEC) begin
                dst_q <= bus.alu_dst;
                ov_q  <= bus.alu_ov;
                zr_q  <= bus.alu_zr;
                neg_q <= bus.alu_neg;
            end
        end
    end

    assign bus.req0_rdy  = gnt0;
    assign bus.req1_rdy  = gnt1;
    assign bus.alu_op    = op_q;
    assign bus.alu_src0  = src0_q;
    assign bus.alu_src1  = src1_q;
    assign bus.alu_shamt = shamt_q;
    assign bus.rsp_vld   = state_q == RESP;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_dst   = dst_q;
    assign bus.rsp_ov    = ov_q;
    assign bus.rsp_zr    = zr_q;
    assign bus.rsp_neg   = neg_q;
    assign bus.flags0    = flags0_q;
    assign bus.flags1    = flags1_q;
endmodule
